// File: rtl/prio_scan_encoder.sv
// rtl/prio_scan_encoder.sv - registered priority scan encoder, highest set index first
// Optional macro PRIO_SCAN_CNT_EN adds o_cnt, the number of indices still pending.
module prio_scan_encoder #(
    parameter int WIDTH = 8,
    parameter int IDX_W = 3
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_load,
    input  logic [WIDTH-1:0] i_x,
    input  logic             i_ready,
    output logic [IDX_W-1:0] o_y,
    output logic             o_valid,
    output logic             o_indicate,
    output logic             o_busy,
    output logic             o_done
`ifdef PRIO_SCAN_CNT_EN
    ,
    output logic [IDX_W:0]   o_cnt
`endif
);

    typedef enum logic {IDLE = 1'b0, SCAN = 1'b1} state_t;

    function automatic logic [IDX_W-1:0] hi(input logic [WIDTH-1:0] v);
        logic [IDX_W-1:0] r;
        r = '0;
        for (int i = 0; i < WIDTH; i++)
            if (v[i]) r = IDX_W'(i);
        return r;
    endfunction

    state_t           r_state, w_state;
    logic [WIDTH-1:0] r_pending, w_pending;
    logic [IDX_W-1:0] r_y, w_y;
    logic             r_valid, w_valid;
    logic             r_indicate, w_indicate;
    logic             r_busy, w_busy;
    logic             r_done, w_done;
    logic             w_acc;
    logic [WIDTH-1:0] w_rest;

`ifdef PRIO_SCAN_CNT_EN
    logic [IDX_W:0]   r_cnt, w_cnt;

    function automatic logic [IDX_W:0] pop(input logic [WIDTH-1:0] v);
        logic [IDX_W:0] c;
        c = '0;
        for (int i = 0; i < WIDTH; i++)
            c = c + {{IDX_W{1'b0}}, v[i]};
        return c;
    endfunction
`endif

    assign w_acc  = i_en & r_valid & i_ready;
    assign w_rest = r_pending & ~(WIDTH'(1) << r_y);

    always_comb begin
        w_state    = r_state;
        w_pending  = r_pending;
        w_y        = r_y;
        w_valid    = r_valid;
        w_indicate = r_indicate;
        w_busy     = r_busy;
        w_done     = 1'b0;
`ifdef PRIO_SCAN_CNT_EN
        w_cnt      = r_cnt;
`endif
        case (r_state)
            IDLE: begin
                if (i_en && i_load) begin
                    if (|i_x) begin
                        w_pending  = i_x;
                        w_y        = hi(i_x);
                        w_valid    = 1'b1;
                        w_indicate = 1'b1;
                        w_busy     = 1'b1;
                        w_state    = SCAN;
`ifdef PRIO_SCAN_CNT_EN
                        w_cnt      = pop(i_x);
`endif
                    end else begin
                        w_pending = '0;
                        w_done    = 1'b1;
                    end
                end
            end
            SCAN: begin
                // load is deliberately ignored here; only an accept advances the scan
                if (w_acc) begin
                    w_pending = w_rest;
`ifdef PRIO_SCAN_CNT_EN
                    w_cnt     = r_cnt - 1'b1;
`endif
                    if (|w_rest) begin
                        w_y = hi(w_rest);
                    end else begin
                        w_valid    = 1'b0;
                        w_indicate = 1'b0;
                        w_busy     = 1'b0;
                        w_done     = 1'b1;
                        w_state    = IDLE;
                    end
                end
            end
            default: w_state = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state    <= IDLE;
            r_pending  <= '0;
            r_y        <= '0;
            r_valid    <= 1'b0;
            r_indicate <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
`ifdef PRIO_SCAN_CNT_EN
            r_cnt      <= '0;
`endif
        end else begin
            r_state    <= w_state;
            r_pending  <= w_pending;
            r_y        <= w_y;
            r_valid    <= w_valid;
            r_indicate <= w_indicate;
            r_busy     <= w_busy;
            r_done     <= w_done;
`ifdef PRIO_SCAN_CNT_EN
            r_cnt      <= w_cnt;
`endif
        end
    end

    assign o_y        = r_y;
    assign o_valid    = r_valid;
    assign o_indicate = r_indicate;
    assign o_busy     = r_busy;
    assign o_done     = r_done;
`ifdef PRIO_SCAN_CNT_EN
    assign o_cnt      = r_cnt;
`endif

endmodule

// File: tb/tb_prio_scan_encoder.sv
// tb/tb_prio_scan_encoder.sv - directed bench for prio_scan_encoder (8-bit and 16-bit instances)
module tb_prio_scan_encoder;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_en, a_load, a_ready;
    logic [7:0]  a_x;
    logic [2:0]  a_y;
    logic        a_valid, a_ind, a_busy, a_done;
    logic        b_en, b_load, b_ready;
    logic [15:0] b_x;
    logic [3:0]  b_y;
    logic        b_valid, b_ind, b_busy, b_done;
`ifdef PRIO_SCAN_CNT_EN
    logic [3:0]  a_cnt;
    logic [4:0]  b_cnt;
`endif

    int n_checks = 0;
    int n_err    = 0;

    always #5 clk = ~clk;

    prio_scan_encoder #(.WIDTH(8), .IDX_W(3)) dut_a (
        .i_clk(clk), .i_rst(rst), .i_en(a_en), .i_load(a_load), .i_x(a_x),
        .i_ready(a_ready), .o_y(a_y), .o_valid(a_valid), .o_indicate(a_ind),
        .o_busy(a_busy), .o_done(a_done)
`ifdef PRIO_SCAN_CNT_EN
        , .o_cnt(a_cnt)
`endif
    );

    prio_scan_encoder #(.WIDTH(16), .IDX_W(4)) dut_b (
        .i_clk(clk), .i_rst(rst), .i_en(b_en), .i_load(b_load), .i_x(b_x),
        .i_ready(b_ready), .o_y(b_y), .o_valid(b_valid), .o_indicate(b_ind),
        .o_busy(b_busy), .o_done(b_done)
`ifdef PRIO_SCAN_CNT_EN
        , .o_cnt(b_cnt)
`endif
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // status = {valid, indicate, busy, done}
    function automatic logic [3:0] sa();
        return {a_valid, a_ind, a_busy, a_done};
    endfunction

    initial begin
        rst = 1'b1; a_en = 1'b1; a_load = 1'b0; a_x = '0; a_ready = 1'b0;
        b_en = 1'b1; b_load = 1'b0; b_x = '0; b_ready = 1'b0;
        tick(); tick();
        chk("reset_y", a_y, 0);
        chk("reset_status", sa(), 4'b0000);
        rst = 1'b0;

        // burst scan, ready held high
        a_x = 8'b1010_0101; a_load = 1'b1; a_ready = 1'b1;
        tick(); a_load = 1'b0;
        chk("burst_y0", a_y, 7);
        chk("burst_st0", sa(), 4'b1110);
        tick(); chk("burst_y1", a_y, 5);
        tick(); chk("burst_y2", a_y, 2);
        tick(); chk("burst_y3", a_y, 0);
        chk("burst_st3", sa(), 4'b1110);
        tick(); chk("burst_end", sa(), 4'b0001);
        chk("burst_y_keep", a_y, 0);
        tick(); chk("burst_done_clr", sa(), 4'b0000);

        // backpressure
        a_ready = 1'b0; a_x = 8'h90; a_load = 1'b1;
        tick(); a_load = 1'b0;
        chk("bp_y_a", a_y, 7);
        tick(); chk("bp_y_b", a_y, 7);
        tick(); chk("bp_y_c", a_y, 7);
        chk("bp_st", sa(), 4'b1110);
        a_ready = 1'b1;
        tick(); chk("bp_y4", a_y, 4);
        tick(); chk("bp_end", sa(), 4'b0001);
        a_ready = 1'b0;
        tick(); chk("bp_done_clr", sa(), 4'b0000);

        // zero capture
        a_x = 8'h00; a_load = 1'b1;
        tick(); a_load = 1'b0;
        chk("zero_done", sa(), 4'b0001);
        tick(); chk("zero_clr", sa(), 4'b0000);

        // enable freeze and load ignored during SCAN
        a_x = 8'h0C; a_load = 1'b1;
        tick(); a_load = 1'b0;
        chk("en_y3", a_y, 3);
        a_en = 1'b0; a_ready = 1'b1;
        tick(); chk("en_off_y_a", a_y, 3);
        tick(); chk("en_off_y_b", a_y, 3);
        chk("en_off_st", sa(), 4'b1110);
        a_en = 1'b1; a_ready = 1'b0; a_x = 8'hFF; a_load = 1'b1;
        tick(); chk("scan_load_ign", a_y, 3);
        a_load = 1'b0; a_ready = 1'b1;
        tick(); chk("seq_y2", a_y, 2);
        // load coincident with final accept is dropped, then honoured from IDLE
        a_x = 8'h40; a_load = 1'b1;
        tick(); chk("final_acc_load", sa(), 4'b0001);
        a_ready = 1'b0;
        tick(); chk("reload_y", a_y, 6);
        chk("reload_st", sa(), 4'b1110);
        a_load = 1'b0; a_ready = 1'b1;
        tick(); chk("reload_end", sa(), 4'b0001);
        a_ready = 1'b0;

        // async reset mid-scan
        a_x = 8'b1010_0001; a_load = 1'b1;
        tick(); a_load = 1'b0;
        chk("pre_rst_y", a_y, 7);
        rst = 1'b1; #2;
        chk("async_rst_y", a_y, 0);
        chk("async_rst_st", sa(), 4'b0000);
        tick(); rst = 1'b0;
        chk("rst_no_done", a_done, 0);
        a_x = 8'h01; a_load = 1'b1;
        tick(); a_load = 1'b0;
        chk("post_rst_y", a_y, 0);
        chk("post_rst_v", a_valid, 1);
        a_ready = 1'b1;
        tick(); chk("post_rst_end", sa(), 4'b0001);
        a_ready = 1'b0;

        // 16-bit instance
        b_x = 16'h8001; b_load = 1'b1;
        tick(); b_load = 1'b0;
        chk("w16_y15", b_y, 15);
        chk("w16_v", b_valid, 1);
`ifdef PRIO_SCAN_CNT_EN
        chk("w16_cnt2", b_cnt, 2);
`endif
        b_ready = 1'b1;
        tick(); chk("w16_y0", b_y, 0);
`ifdef PRIO_SCAN_CNT_EN
        chk("w16_cnt1", b_cnt, 1);
`endif
        tick(); chk("w16_end", {b_valid, b_ind, b_busy, b_done}, 4'b0001);
`ifdef PRIO_SCAN_CNT_EN
        chk("w16_cnt0", b_cnt, 0);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule
